decode_stage: RTL and testbench

- Registered, handshaked instruction-decode stage for the 32-bit processor. Sits between fetch and execute, one pipeline register deep.
- Decodes the existing instruction format:
  - bit31 = immediate mode
  - [30:25] rs, [24:19] rd, [18:15] opcode
  - [14:9] rt (register mode), imm [14:0] (immediate mode) or [8:0] (register mode)
- Adds valid/ready flow control, a load-use scoreboard that stalls dependent instructions, flush, and illegal-opcode detection.

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_if.sv | 49 ++++
 rtl/decode_comb.sv | 40 ++++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction-decode stage.
// Covers the opcode map, the ALU select codes and the registered decode bundle.
package decode_pkg;

    localparam int unsigned D      = 32;
    localparam int unsigned RWIDTH = 6;
    localparam int unsigned IMM_IN = 15;
    localparam int unsigned NREGS  = 1 << RWIDTH;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_MOV   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0110,
        OP_AND   = 4'b1000,
        OP_OR    = 4'b1001,
        OP_XOR   = 4'b1010,
        OP_NOT   = 4'b1011,
        OP_SLL   = 4'b1101,
        OP_NOP   = 4'b1111
    } opcode_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_PASS = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOT  = 4'b1011;
    localparam logic [3:0] ALU_SLL  = 4'b1101;

    typedef struct packed {
        logic [RWIDTH-1:0] rs;
        logic [RWIDTH-1:0] rd;
        logic [RWIDTH-1:0] rt;
        logic [IMM_IN-1:0] imm;
        logic [3:0]        alu_op;
        logic              mux_sel1;
        logic              mux_sel2;
        logic              we1;
        logic              we2;
        logic              illegal;
    } decoded_t;

    localparam decoded_t DecodedReset = '{
        rs: '0, rd: '0, rt: '0, imm: '0, alu_op: ALU_PASS,
        mux_sel1: 1'b0, mux_sel2: 1'b0, we1: 1'b0, we2: 1'b0, illegal: 1'b0
    };

endpackage

// File: rtl/decode_if.sv
// Fetch/execute/writeback signal bundle of the decode stage.
// DECODE_STALL_CNT_EN adds the stall_cnt and illegal_cnt statistics outputs.
interface decode_if;
    import decode_pkg::*;

    logic              in_valid;
    logic [D-1:0]      in_instr;
    logic              in_ready;
    logic              flush;
    logic              wb_valid;
    logic [RWIDTH-1:0] wb_rd;
    logic              out_valid;
    logic              out_ready;
    logic [RWIDTH-1:0] rs;
    logic [RWIDTH-1:0] rd;
    logic [RWIDTH-1:0] rt;
    logic [IMM_IN-1:0] imm;
    logic [3:0]        ALUopsel;
    logic              MUXsel1;
    logic              MUXsel2;
    logic              WE1;
    logic              WE2;
    logic              illegal;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0]       stall_cnt;
    logic [15:0]       illegal_cnt;
`endif

    // Environment side: fetch, execute and writeback.
    modport master (
        output in_valid, in_instr, flush, wb_valid, wb_rd, out_ready,
        input  in_ready, out_valid, rs, rd, rt, imm, ALUopsel, MUXsel1, MUXsel2,
        input  WE1, WE2, illegal
`ifdef DECODE_STALL_CNT_EN
        , input stall_cnt, illegal_cnt
`endif
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, flush, wb_valid, wb_rd, out_ready,
        output in_ready, out_valid, rs, rd, rt, imm, ALUopsel, MUXsel1, MUXsel2,
        output WE1, WE2, illegal
`ifdef DECODE_STALL_CNT_EN
        , output stall_cnt, illegal_cnt
`endif
    );

endinterface

// File: rtl/decode_comb.sv
// Purely combinational field extraction and control-flag decode of one
// instruction word.
module decode_comb
    import decode_pkg::*;
(
    input  logic [D-1:0] instr_i,
    output decoded_t     dec_o
);

    logic    imm_mode;
    opcode_e opcode;

    assign imm_mode = instr_i[31];
    assign opcode   = opcode_e'(instr_i[18:15]);

    always_comb begin
        dec_o          = DecodedReset;
        dec_o.rs       = instr_i[30:25];
        dec_o.rd       = instr_i[24:19];
        dec_o.rt       = imm_mode ? '0 : instr_i[14:9];
        dec_o.imm      = imm_mode ? instr_i[14:0] : {{(IMM_IN - 9){1'b0}}, instr_i[8:0]};
        dec_o.mux_sel1 = imm_mode;

        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SLL: begin
                dec_o.alu_op = opcode;
                dec_o.we1    = 1'b1;
            end
            OP_MOV:   dec_o.we1 = 1'b1;
            OP_LOAD: begin
                dec_o.mux_sel2 = 1'b1;
                dec_o.we1      = 1'b1;
            end
            OP_STORE: dec_o.we2 = 1'b1;
            OP_NOP:   dec_o.we1 = 1'b0;
            default:  dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with load-use scoreboard and flush.
// DECODE_STALL_CNT_EN enables saturating stall/illegal statistics counters.
module decode_stage
    import decode_pkg::*;
(
    input logic     clk,
    input logic     rst,
    decode_if.slave bus
);

    decoded_t         dec_in;
    decoded_t         dec_q, dec_d;
    logic             valid_q, valid_d;
    logic [NREGS-1:0] sb_q, sb_d;
    logic             rs_haz, rt_haz, hazard;
    logic             accept, consume;

    decode_comb u_decode_comb (
        .instr_i (bus.in_instr),
        .dec_o   (dec_in)
    );

    // A held LOAD counts as pending even before it sets its scoreboard bit.
    always_comb begin
        rs_haz = sb_q[dec_in.rs] ||
                 (valid_q && dec_q.mux_sel2 && (dec_q.rd == dec_in.rs));
        rt_haz = !dec_in.mux_sel1 &&
                 (sb_q[dec_in.rt] || (valid_q && dec_q.mux_sel2 && (dec_q.rd == dec_in.rt)));
        hazard = rs_haz || rt_haz;
    end

    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = valid_q && bus.out_ready && !bus.flush;

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec_in;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // Set after clear so a same-index set wins.
    always_comb begin
        sb_d = sb_q;
        if (bus.wb_valid) begin
            sb_d[bus.wb_rd] = 1'b0;
        end
        if (consume && dec_q.mux_sel2) begin
            sb_d[dec_q.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= DecodedReset;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            sb_q    <= sb_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.rs        = dec_q.rs;
    assign bus.rd        = dec_q.rd;
    assign bus.rt        = dec_q.rt;
    assign bus.imm       = dec_q.imm;
    assign bus.ALUopsel  = dec_q.alu_op;
    assign bus.MUXsel1   = dec_q.mux_sel1;
    assign bus.MUXsel2   = dec_q.mux_sel2;
    assign bus.WE1       = dec_q.we1;
    assign bus.WE2       = dec_q.we2;
    assign bus.illegal   = dec_q.illegal;

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (bus.in_valid && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (accept && dec_in.illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  rs;
        logic [5:0]  rd;
        logic [5:0]  rt;
        logic [14:0] imm;
        logic [3:0]  alu;
        logic        m1;
        logic        m2;
        logic        we1;
        logic        we2;
        logic        ill;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_init  = 1'b0;
    logic        m_valid;
    exp_t        m_held;
    bit   [63:0] m_sb;
    logic [31:0] m_stall;
    logic [15:0] m_ill;
    logic        m_acc;
    logic        s_ready;

    function automatic logic [31:0] mk(input logic im, input logic [5:0] rs, input logic [5:0] rd,
                                       input logic [3:0] op, input logic [14:0] low);
        return {im, rs, rd, op, low};
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [3:0] op;
        logic       legal;
        op      = w[18:15];
        legal   = !(op inside {4'b0001, 4'b0101, 4'b0111, 4'b1100, 4'b1110});
        e.rs    = w[30:25];
        e.rd    = w[24:19];
        e.rt    = w[31] ? 6'd0 : w[14:9];
        e.imm   = w[31] ? w[14:0] : {6'd0, w[8:0]};
        e.alu   = (op inside {4'b0000, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101})
                  ? op : 4'b0010;
        e.m1    = w[31];
        e.m2    = (op == 4'b0100);
        e.we2   = (op == 4'b0110);
        e.we1   = legal && (op != 4'b1111) && (op != 4'b0110);
        e.ill   = !legal;
        return e;
    endfunction

    // A source is busy if a load already issued or the load sitting in the stage targets it.
    function automatic logic busy(input logic [5:0] r);
        return m_sb[r] || (m_valid && m_held.m2 && (m_held.rd == r));
    endfunction

    function automatic logic model_hazard(input logic [31:0] w);
        return busy(w[30:25]) || (!w[31] && busy(w[14:9]));
    endfunction

    function automatic logic model_ready(input logic [31:0] w, input logic ordy, input logic fl);
        return (!m_valid || ordy) && !model_hazard(w) && !fl;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic iv, input logic [31:0] w,
                              input logic ordy, input logic fl, input logic wv,
                              input logic [5:0] wr);
        logic haz, acc, cons;
        exp_t d;
        if (r) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_sb    = '0;
            m_stall = '0;
            m_ill   = '0;
            m_acc   = 1'b0;
            return;
        end
        haz  = model_hazard(w);
        acc  = iv && model_ready(w, ordy, fl);
        cons = m_valid && ordy && !fl;
        d    = ref_decode(w);
        if (iv && haz && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
        if (acc && d.ill && (m_ill != 16'hFFFF)) m_ill = m_ill + 1;
        if (wv) m_sb[wr] = 1'b0;
        if (cons && m_held.m2) m_sb[m_held.rd] = 1'b1;
        if (fl) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_held  = d;
        end else if (cons) m_valid = 1'b0;
        m_acc = acc;
    endtask

    task automatic check_regs();
        chk("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            chk("rs", bus.rs, m_held.rs);
            chk("rd", bus.rd, m_held.rd);
            chk("rt", bus.rt, m_held.rt);
            chk("imm", bus.imm, m_held.imm);
            chk("ALUopsel", bus.ALUopsel, m_held.alu);
            chk("MUXsel1", bus.MUXsel1, m_held.m1);
            chk("MUXsel2", bus.MUXsel2, m_held.m2);
            chk("WE1", bus.WE1, m_held.we1);
            chk("WE2", bus.WE2, m_held.we2);
            chk("illegal", bus.illegal, m_held.ill);
        end
`ifdef DECODE_STALL_CNT_EN
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("illegal_cnt", bus.illegal_cnt, m_ill);
`endif
    endtask

    // One clock: drive inputs, check in_ready, clock edge, check registered outputs.
    task automatic step(input logic r, input logic iv, input logic [31:0] w, input logic ordy,
                        input logic fl, input logic wv, input logic [5:0] wr);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_instr  = w;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
        #1;
        s_ready = bus.in_ready;
        if (m_init) chk("in_ready", s_ready, model_ready(w, ordy, fl));
        @(posedge clk);
        model_step(r, iv, w, ordy, fl, wv, wr);
        #1;
        check_regs();
    endtask

    initial begin
        logic [31:0] addi, load7, add7, load3, subi, add0, load5, add5, ill, add3;
        logic [31:0] w;
        logic        hold;
        logic [3:0]  op;

        addi  = mk(1'b1, 6'd1, 6'd4, 4'b0000, 15'd5);
        load7 = mk(1'b0, 6'd0, 6'd7, 4'b0100, 15'd0);
        add7  = mk(1'b0, 6'd7, 6'd2, 4'b0000, 15'd0);
        load3 = mk(1'b0, 6'd0, 6'd3, 4'b0100, 15'd0);
        subi  = mk(1'b1, 6'd0, 6'd1, 4'b0011, 15'h0600);
        add0  = mk(1'b0, 6'd0, 6'd1, 4'b0000, 15'd0);
        load5 = mk(1'b0, 6'd0, 6'd5, 4'b0100, 15'd0);
        add5  = mk(1'b0, 6'd5, 6'd2, 4'b0000, 15'd0);
        ill   = mk(1'b0, 6'd0, 6'd6, 4'b0101, 15'd0);
        add3  = mk(1'b0, 6'd3, 6'd2, 4'b0000, 15'd0);

        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ALUopsel", bus.ALUopsel, 4'b0010);
        chk("rst_rs", bus.rs, 6'd0);
        chk("rst_imm", bus.imm, 15'd0);
        chk("rst_WE1", bus.WE1, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);

        step(0, 1, addi, 1, 0, 0, 0);
        chk("addi_ready", s_ready, 1'b1);
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_rs", bus.rs, 6'd1);
        chk("addi_rd", bus.rd, 6'd4);
        chk("addi_rt", bus.rt, 6'd0);
        chk("addi_imm", bus.imm, 15'd5);
        chk("addi_MUXsel1", bus.MUXsel1, 1'b1);
        chk("addi_WE1", bus.WE1, 1'b1);
        chk("addi_ALUopsel", bus.ALUopsel, 4'b0000);

        step(0, 1, load7, 1, 0, 0, 0);
        step(0, 1, add7, 1, 0, 0, 0);
        chk("lu_stall_held", s_ready, 1'b0);
        step(0, 1, add7, 1, 0, 0, 0);
        chk("lu_stall_sb", s_ready, 1'b0);
        step(0, 1, add7, 1, 0, 1, 6'd7);
        chk("lu_stall_wb", s_ready, 1'b0);
        step(0, 1, add7, 1, 0, 0, 0);
        chk("lu_release", s_ready, 1'b1);
        chk("lu_add_rs", bus.rs, 6'd7);

        step(0, 1, load3, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, subi, 1, 0, 0, 0);
        chk("immrt_ready", s_ready, 1'b1);
        chk("immrt_ALUopsel", bus.ALUopsel, 4'b0011);

        for (int i = 0; i < 4; i++) begin
            step(0, 1, add0, 0, 0, 0, 0);
            chk("bp_ready", s_ready, 1'b0);
            chk("bp_imm", bus.imm, 15'h0600);
            chk("bp_valid", bus.out_valid, 1'b1);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        chk("bp_drain", bus.out_valid, 1'b0);

        step(0, 1, load5, 1, 0, 0, 0);
        chk("fl_load_MUXsel2", bus.MUXsel2, 1'b1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("fl_valid", bus.out_valid, 1'b0);
        step(0, 1, add5, 1, 0, 0, 0);
        chk("fl_no_sb", s_ready, 1'b1);
        step(0, 1, ill, 1, 0, 0, 0);
        chk("ill_flag", bus.illegal, 1'b1);
        chk("ill_WE1", bus.WE1, 1'b0);
        chk("ill_WE2", bus.WE2, 1'b0);
        chk("ill_ALUopsel", bus.ALUopsel, 4'b0010);
`ifdef DECODE_STALL_CNT_EN
        chk("ill_cnt", bus.illegal_cnt, 16'd1);
        chk("stall_cnt3", bus.stall_cnt, 32'd3);
`endif

        step(0, 1, add3, 0, 0, 0, 0);
        chk("rs_stall_sb3", s_ready, 1'b0);
        step(1, 1, add3, 1, 0, 0, 0);
        chk("rs_rst_valid", bus.out_valid, 1'b0);
        chk("rs_rst_ALUopsel", bus.ALUopsel, 4'b0010);
        step(0, 1, add3, 1, 0, 0, 0);
        chk("rs_sb_cleared", s_ready, 1'b1);

        hold = 1'b0;
        w    = '0;
        for (int i = 0; i < 4000; i++) begin
            logic iv;
            iv = hold || ($urandom_range(0, 9) < 8);
            if (!hold) begin
                op = ($urandom_range(0, 2) == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
                w  = mk(1'($urandom), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), op,
                        {6'($urandom_range(0, 3)), 9'($urandom)});
            end
            step(($urandom_range(0, 199) == 0), iv, w, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 6'($urandom_range(0, 3)));
            hold = iv && !m_acc && !rst;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
